// File: rtl/vending_multi.sv
// Parametrised multi-item vending controller: price-load phase, saturating credit,
// per-item stock, cancel/refund and reject pulses. All outputs are registered.
module vending_multi #(
    parameter int N_ITEMS    = 3,
    parameter int W          = 8,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 2,
    parameter int SEL_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [W-1:0]       DI,
    input  logic [W-1:0]       MI,
    input  logic [SEL_W-1:0]   sel,
    input  logic               cancel,
    output logic [W-1:0]       MO,
    output logic [SEL_W-1:0]   PO,
    output logic               done,
    output logic               reject,
    output logic               ready,
    output logic [N_ITEMS-1:0] empty
);

    localparam int IDX_W = $clog2(N_ITEMS + 1);

    typedef enum logic {LOAD, IDLE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       credit;
    logic [W-1:0]       price [N_ITEMS];
    logic [STOCK_W-1:0] stock [N_ITEMS];

    logic [W:0]         sum;
    logic [W-1:0]       credit_next;
    logic [W-1:0]       sel_price;
    logic [STOCK_W-1:0] sel_stock;
    logic               sel_hit;
    logic               vend_ok;

    // Credit saturates at all-ones instead of wrapping.
    always_comb begin
        sum         = {1'b0, credit} + {1'b0, MI};
        credit_next = sum[W] ? '1 : sum[W-1:0];
    end

    always_comb begin
        sel_hit   = 1'b0;
        sel_price = '0;
        sel_stock = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel == SEL_W'(i + 1)) begin
                sel_hit   = 1'b1;
                sel_price = price[i];
                sel_stock = stock[i];
            end
        end
        vend_ok = sel_hit && (credit_next >= sel_price) && (sel_stock != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= LOAD;
            idx    <= '0;
            credit <= '0;
            for (int i = 0; i < N_ITEMS; i++) begin
                price[i] <= '0;
                stock[i] <= STOCK_W'(STOCK_INIT);
            end
            MO     <= '0;
            PO     <= '0;
            done   <= 1'b0;
            reject <= 1'b0;
            ready  <= 1'b0;
            empty  <= {N_ITEMS{(STOCK_INIT == 0)}};
        end else begin
            MO     <= '0;
            PO     <= '0;
            done   <= 1'b0;
            reject <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (load_en) begin
                        for (int i = 0; i < N_ITEMS; i++) begin
                            if (idx == IDX_W'(i)) price[i] <= DI;
                        end
                        idx <= idx + 1'b1;
                        if (idx == IDX_W'(N_ITEMS - 1)) begin
                            state <= IDLE;
                            ready <= 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (cancel) begin
                        MO     <= credit_next;
                        done   <= 1'b1;
                        credit <= '0;
                    end else if (vend_ok) begin
                        PO     <= sel;
                        MO     <= credit_next - sel_price;
                        done   <= 1'b1;
                        credit <= '0;
                        for (int i = 0; i < N_ITEMS; i++) begin
                            if (sel == SEL_W'(i + 1)) begin
                                stock[i] <= stock[i] - 1'b1;
                                empty[i] <= (stock[i] == STOCK_W'(1));
                            end
                        end
                    end else if (sel != '0) begin
                        reject <= 1'b1;
                        credit <= credit_next;
                    end else begin
                        credit <= credit_next;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_multi.sv
// Self-checking bench for vending_multi: directed vector table, async reset
// sequence, and randomized traffic against a behavioural model.
module tb_vending_multi;

    logic       clk;
    logic       rst;
    logic       load_en;
    logic [7:0] DI;
    logic [7:0] MI;
    logic [1:0] sel;
    logic       cancel;
    logic [7:0] MO;
    logic [1:0] PO;
    logic       done;
    logic       reject;
    logic       ready;
    logic [2:0] empty;

    int errors = 0;
    int checks = 0;

    vending_multi #(
        .N_ITEMS(3), .W(8), .STOCK_W(4), .STOCK_INIT(2), .SEL_W(2)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .DI(DI), .MI(MI),
        .sel(sel), .cancel(cancel), .MO(MO), .PO(PO), .done(done),
        .reject(reject), .ready(ready), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       le;
        logic [7:0] di;
        logic [7:0] mi;
        logic [1:0] s;
        logic       c;
        logic       dn;
        logic       rj;
        logic       rd;
        logic [7:0] mo;
        logic [1:0] po;
        logic [2:0] em;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic le, logic [7:0] di, logic [7:0] mi,
                                logic [1:0] s, logic c, logic dn, logic rj,
                                logic rd, logic [7:0] mo, logic [1:0] po,
                                logic [2:0] em);
        vec_t v;
        v.le = le; v.di = di; v.mi = mi; v.s = s; v.c = c;
        v.dn = dn; v.rj = rj; v.rd = rd; v.mo = mo; v.po = po; v.em = em;
        return v;
    endfunction

    task automatic check(string name, logic dn, logic rj, logic rd,
                         logic [7:0] mo, logic [1:0] po, logic [2:0] em);
        checks++;
        if ({done, reject, ready, MO, PO, empty} !== {dn, rj, rd, mo, po, em}) begin
            errors++;
            $display("FAIL %s: got done=%b reject=%b ready=%b MO=%0d PO=%0d empty=%b, want done=%b reject=%b ready=%b MO=%0d PO=%0d empty=%b",
                     name, done, reject, ready, MO, PO, empty, dn, rj, rd, mo, po, em);
        end
    endtask

    task automatic step(logic le, logic [7:0] di, logic [7:0] mi,
                        logic [1:0] s, logic c);
        load_en = le; DI = di; MI = mi; sel = s; cancel = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        load_en = 0; DI = 0; MI = 0; sel = 0; cancel = 0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    // Behavioural reference: plain integers for prices, stock and credit.
    task automatic rand_round(int n, int round);
        int price[3];
        int stock[3];
        int credit;
        int loaded;
        int mis[8] = '{0, 0, 5, 10, 25, 50, 100, 200};
        do_reset();
        credit = 0;
        loaded = 0;
        for (int i = 0; i < 3; i++) begin
            price[i] = 0;
            stock[i] = 2;
        end
        for (int t = 0; t < n; t++) begin
            logic       le, c;
            logic [7:0] di, mi;
            logic [1:0] s;
            int         cn, k;
            logic       e_dn, e_rj;
            int         e_mo, e_po;
            logic [2:0] e_em;
            le = 1'($urandom_range(0, 1));
            di = 8'($urandom_range(0, 120));
            mi = 8'(mis[$urandom_range(0, 7)]);
            s  = 2'($urandom_range(0, 3));
            c  = ($urandom_range(0, 7) == 0);
            e_dn = 0; e_rj = 0; e_mo = 0; e_po = 0;
            if (loaded < 3) begin
                if (le) begin
                    price[loaded] = di;
                    loaded++;
                end
            end else begin
                cn = credit + mi;
                if (cn > 255) cn = 255;
                k = s;
                if (c) begin
                    e_dn = 1; e_mo = cn; credit = 0;
                end else if (k != 0 && cn >= price[k-1] && stock[k-1] > 0) begin
                    e_dn = 1; e_po = k; e_mo = cn - price[k-1];
                    stock[k-1]--;
                    credit = 0;
                end else if (k != 0) begin
                    e_rj = 1; credit = cn;
                end else begin
                    credit = cn;
                end
            end
            for (int i = 0; i < 3; i++) e_em[i] = (stock[i] == 0);
            step(le, di, mi, s, c);
            check($sformatf("rand r%0d t%0d", round, t), e_dn, e_rj,
                  (loaded == 3), 8'(e_mo), 2'(e_po), e_em);
        end
    endtask

    initial begin
        rst = 1'b0;
        load_en = 0; DI = 0; MI = 0; sel = 0; cancel = 0;
        #2;
        check("reset state", 0, 0, 0, 0, 0, 3'b000);
        #10;
        rst = 1'b1;

        vecs.push_back(mk(1, 30, 10, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 50, 10, 2, 1, 0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 70, 10, 0, 0, 0, 0, 1, 0, 0, 3'b000));
        vecs.push_back(mk(0, 0, 20, 0, 0, 0, 0, 1, 0, 0, 3'b000));
        vecs.push_back(mk(0, 0, 20, 2, 0, 0, 1, 1, 0, 0, 3'b000));
        vecs.push_back(mk(0, 0, 20, 2, 0, 1, 0, 1, 10, 2, 3'b000));
        vecs.push_back(mk(0, 0, 30, 1, 0, 1, 0, 1, 0, 1, 3'b000));
        vecs.push_back(mk(0, 0, 30, 1, 0, 1, 0, 1, 0, 1, 3'b001));
        vecs.push_back(mk(0, 0, 30, 1, 0, 0, 1, 1, 0, 0, 3'b001));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 30, 0, 3'b001));
        vecs.push_back(mk(0, 0, 200, 0, 0, 0, 0, 1, 0, 0, 3'b001));
        vecs.push_back(mk(0, 0, 100, 0, 0, 0, 0, 1, 0, 0, 3'b001));
        vecs.push_back(mk(0, 0, 0, 3, 0, 1, 0, 1, 185, 3, 3'b001));
        vecs.push_back(mk(0, 0, 60, 0, 0, 0, 0, 1, 0, 0, 3'b001));
        vecs.push_back(mk(0, 0, 0, 2, 1, 1, 0, 1, 60, 0, 3'b001));
        vecs.push_back(mk(0, 0, 0, 3, 0, 0, 1, 1, 0, 0, 3'b001));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 3'b001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b001));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b001));
        vecs.push_back(mk(0, 0, 50, 2, 0, 1, 0, 1, 0, 2, 3'b011));
        vecs.push_back(mk(0, 0, 50, 2, 0, 0, 1, 1, 0, 0, 3'b011));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 50, 0, 3'b011));
        vecs.push_back(mk(0, 0, 70, 3, 0, 1, 0, 1, 0, 3, 3'b111));

        foreach (vecs[i]) begin
            step(vecs[i].le, vecs[i].di, vecs[i].mi, vecs[i].s, vecs[i].c);
            check($sformatf("vec %0d", i), vecs[i].dn, vecs[i].rj, vecs[i].rd,
                  vecs[i].mo, vecs[i].po, vecs[i].em);
        end

        // Async reset mid-credit: outputs clear at once, credit is lost.
        step(0, 0, 60, 0, 0);
        check("credit 60 held", 0, 0, 1, 0, 0, 3'b111);
        MI = 0;
        #2;
        rst = 1'b0;
        #1;
        check("async reset clears", 0, 0, 0, 0, 0, 3'b000);
        #1;
        rst = 1'b1;
        step(1, 30, 0, 0, 0);
        check("reload 1", 0, 0, 0, 0, 0, 3'b000);
        step(1, 50, 0, 0, 0);
        step(1, 70, 0, 0, 0);
        check("reload done", 0, 0, 1, 0, 0, 3'b000);
        step(0, 0, 0, 0, 1);
        check("no refund after reset", 1, 0, 1, 0, 0, 3'b000);

        for (int r = 0; r < 3; r++) rand_round(120, r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
